// File: rtl/sdram_master_arbiter_if.sv
// Bus bundle between two Avalon-MM hosts, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface sdram_master_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] h0_address;
   logic          h0_read;
   logic          h0_write;
   logic [DW-1:0] h0_writedata;
   logic          h0_waitrequest;
   logic [DW-1:0] h0_readdata;
   logic          h0_readdatavalid;

   logic [AW-1:0] h1_address;
   logic          h1_read;
   logic          h1_write;
   logic [DW-1:0] h1_writedata;
   logic          h1_waitrequest;
   logic [DW-1:0] h1_readdata;
   logic          h1_readdatavalid;

   logic [AW-1:0] sdram_address;
   logic          sdram_read;
   logic          sdram_write;
   logic [DW-1:0] sdram_writedata;
   logic          sdram_waitrequest;
   logic [DW-1:0] sdram_readdata;
   logic          sdram_readdatavalid;

   modport slave (
      input  h0_address, h0_read, h0_write, h0_writedata,
      output h0_waitrequest, h0_readdata, h0_readdatavalid,
      input  h1_address, h1_read, h1_write, h1_writedata,
      output h1_waitrequest, h1_readdata, h1_readdatavalid,
      output sdram_address, sdram_read, sdram_write, sdram_writedata,
      input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid
   );

   modport master (
      output h0_address, h0_read, h0_write, h0_writedata,
      input  h0_waitrequest, h0_readdata, h0_readdatavalid,
      output h1_address, h1_read, h1_write, h1_writedata,
      input  h1_waitrequest, h1_readdata, h1_readdatavalid,
      input  sdram_address, sdram_read, sdram_write, sdram_writedata,
      output sdram_waitrequest, sdram_readdata, sdram_readdatavalid
   );
endinterface

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master port between two hosts,
// one transaction in flight; read data valid is steered back to the owning host.
module sdram_master_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sdram_master_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t        state_r;
   logic          grant_r;
   logic          last_r;
   logic [AW-1:0] addr_hold_r;
   logic [DW-1:0] wdata_hold_r;

   logic          req0_s;
   logic          req1_s;
   logic          g_read_s;
   logic          g_write_s;
   logic [AW-1:0] g_addr_s;
   logic [DW-1:0] g_wdata_s;

   // Request decode and granted-host operand mux.
   always_comb begin
      req0_s = bus.h0_read | bus.h0_write;
      req1_s = bus.h1_read | bus.h1_write;
      if (grant_r) begin
         g_read_s  = bus.h1_read;
         g_write_s = bus.h1_write;
         g_addr_s  = bus.h1_address;
         g_wdata_s = bus.h1_writedata;
      end else begin
         g_read_s  = bus.h0_read;
         g_write_s = bus.h0_write;
         g_addr_s  = bus.h0_address;
         g_wdata_s = bus.h0_writedata;
      end
   end

   // Arbitration FSM; last_r only moves when the controller actually takes a command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         grant_r      <= 1'b0;
         last_r       <= 1'b1;
         addr_hold_r  <= {AW{1'b0}};
         wdata_hold_r <= {DW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (req0_s || req1_s) begin
                  state_r <= CMD;
                  if (req0_s && req1_s) begin
                     grant_r <= ~last_r;
                  end else begin
                     grant_r <= req1_s;
                  end
               end
            end
            CMD: begin
               if (!(g_read_s || g_write_s)) begin
                  state_r <= IDLE;
               end else begin
                  addr_hold_r  <= g_addr_s;
                  wdata_hold_r <= g_wdata_s;
                  if (!bus.sdram_waitrequest) begin
                     last_r  <= grant_r;
                     state_r <= g_read_s ? RDWAIT : IDLE;
                  end
               end
            end
            RDWAIT: begin
               if (bus.sdram_readdatavalid) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Command and response steering; a read+write collision issues only the read.
   always_comb begin
      bus.sdram_address    = addr_hold_r;
      bus.sdram_writedata  = wdata_hold_r;
      bus.sdram_read       = 1'b0;
      bus.sdram_write      = 1'b0;
      bus.h0_waitrequest   = 1'b1;
      bus.h1_waitrequest   = 1'b1;
      bus.h0_readdatavalid = 1'b0;
      bus.h1_readdatavalid = 1'b0;
      bus.h0_readdata      = bus.sdram_readdata;
      bus.h1_readdata      = bus.sdram_readdata;
      case (state_r)
         CMD: begin
            bus.sdram_address   = g_addr_s;
            bus.sdram_writedata = g_wdata_s;
            bus.sdram_read      = g_read_s;
            bus.sdram_write     = g_write_s & ~g_read_s;
            if (grant_r) begin
               bus.h1_waitrequest = bus.sdram_waitrequest;
            end else begin
               bus.h0_waitrequest = bus.sdram_waitrequest;
            end
         end
         RDWAIT: begin
            bus.h0_readdatavalid = bus.sdram_readdatavalid & ~grant_r;
            bus.h1_readdatavalid = bus.sdram_readdatavalid & grant_r;
         end
         default: begin
            bus.sdram_read = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Bench for sdram_master_arbiter: two host drivers, an SDRAM model with
// programmable stall and 3-cycle read latency, and a read-data scoreboard.
module tb_sdram_master_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sdram_master_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   sdram_master_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] rdq0[$];
   logic [DW-1:0] rdq1[$];
   int            order_q[$];
   int wr_cyc = 0, rd_cyc = 0, w0_low = 0, w1_low = 0;

   // SDRAM model: stall while stall_used < stall_req, read data = f(address), latency 3
   int            stall_req = 0;
   int            stall_used = 0;
   logic          spur = 1'b0;
   logic [2:0]    pv = 3'b000;
   logic [DW-1:0] pd[3] = '{default: '0};

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign bus.sdram_waitrequest   = (stall_used < stall_req);
   assign bus.sdram_readdatavalid = pv[2] | spur;
   assign bus.sdram_readdata      = pd[2];

   always @(posedge clk) begin
      if ((bus.sdram_read || bus.sdram_write) && bus.sdram_waitrequest) stall_used <= stall_used + 1;
      pv    <= {pv[1:0], bus.sdram_read & ~bus.sdram_waitrequest};
      pd[0] <= mem_f(bus.sdram_address);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic monitor();
      logic          p_st = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
      logic [AW-1:0] p_a = '0;
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         if (bus.sdram_write === 1'b1) wr_cyc++;
         if (bus.sdram_read === 1'b1) rd_cyc++;
         if (bus.h0_waitrequest === 1'b0) w0_low++;
         if (bus.h1_waitrequest === 1'b0) w1_low++;
         if (p_st && rst_n) begin
            n_chk++;
            if (bus.sdram_read !== p_rd || bus.sdram_write !== p_wr || bus.sdram_address !== p_a) begin
               n_fail++;
               $display("FAIL stall_hold: got rd=%b wr=%b addr=%h, required rd=%b wr=%b addr=%h",
                        bus.sdram_read, bus.sdram_write, bus.sdram_address, p_rd, p_wr, p_a);
            end
         end
         p_st = (bus.sdram_read | bus.sdram_write) & bus.sdram_waitrequest;
         p_rd = bus.sdram_read;
         p_wr = bus.sdram_write;
         p_a  = bus.sdram_address;
         if (bus.h0_readdatavalid === 1'b1) begin
            n_chk++;
            if (rdq0.size() == 0) begin
               n_fail++;
               $display("FAIL rdv_h0: got unexpected readdatavalid, required none");
            end else begin
               exp = rdq0.pop_front();
               if (bus.h0_readdata !== exp) begin
                  n_fail++;
                  $display("FAIL rdata_h0: got %h, required %h", bus.h0_readdata, exp);
               end
            end
         end
         if (bus.h1_readdatavalid === 1'b1) begin
            n_chk++;
            if (rdq1.size() == 0) begin
               n_fail++;
               $display("FAIL rdv_h1: got unexpected readdatavalid, required none");
            end else begin
               exp = rdq1.pop_front();
               if (bus.h1_readdata !== exp) begin
                  n_fail++;
                  $display("FAIL rdata_h1: got %h, required %h", bus.h1_readdata, exp);
               end
            end
         end
      end
   endtask

   task automatic host_op(input int h, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit done = 1'b0;
      if (h == 0) begin
         bus.h0_address = a; bus.h0_writedata = d; bus.h0_write = wr; bus.h0_read = ~wr;
         if (!wr) rdq0.push_back(mem_f(a));
      end else begin
         bus.h1_address = a; bus.h1_writedata = d; bus.h1_write = wr; bus.h1_read = ~wr;
         if (!wr) rdq1.push_back(mem_f(a));
      end
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (((h == 0) ? bus.h0_waitrequest : bus.h1_waitrequest) === 1'b0) begin
            done = 1'b1;
            order_q.push_back(h);
            n_chk++;
            if (bus.sdram_address !== a || bus.sdram_write !== wr || bus.sdram_read !== ~wr) begin
               n_fail++;
               $display("FAIL cmd_h%0d: got addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                        h, bus.sdram_address, bus.sdram_read, bus.sdram_write, a, ~wr, wr);
            end
            if (wr) begin
               n_chk++;
               if (bus.sdram_writedata !== d) begin
                  n_fail++;
                  $display("FAIL wdata_h%0d: got %h, required %h", h, bus.sdram_writedata, d);
               end
            end
            n_chk++;
            if (((h == 0) ? bus.h1_waitrequest : bus.h0_waitrequest) !== 1'b1) begin
               n_fail++;
               $display("FAIL other_wait_h%0d: got 0, required 1", 1 - h);
            end
         end
         @(posedge clk);
         #1;
      end
      if (h == 0) begin
         bus.h0_read = 1'b0; bus.h0_write = 1'b0;
      end else begin
         bus.h1_read = 1'b0; bus.h1_write = 1'b0;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout_h%0d: got no acceptance in 50 cycles, required acceptance", h);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && (rdq0.size() != 0 || rdq1.size() != 0); n++) @(posedge clk);
      #1;
      n_chk++;
      if (rdq0.size() != 0 || rdq1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d reads outstanding, required 0/0", rdq0.size(), rdq1.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.h0_address = '0; bus.h0_writedata = '0; bus.h0_read = 1'b0; bus.h0_write = 1'b0;
      bus.h1_address = '0; bus.h1_writedata = '0; bus.h1_read = 1'b0; bus.h1_write = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.h0_waitrequest, bus.h1_waitrequest, bus.sdram_read, bus.sdram_write,
           bus.h0_readdatavalid, bus.h1_readdatavalid} !== 6'b110000) begin
         n_fail++;
         $display("FAIL reset_strobes: got w0,w1,rd,wr,v0,v1=%b, required 110000",
                  {bus.h0_waitrequest, bus.h1_waitrequest, bus.sdram_read, bus.sdram_write,
                   bus.h0_readdatavalid, bus.h1_readdatavalid});
      end
      n_chk++;
      if (bus.sdram_address !== 32'h0 || bus.sdram_writedata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: got addr=%h wdata=%h, required 0/0", bus.sdram_address, bus.sdram_writedata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_write();
      int s_w = wr_cyc, s0 = w0_low, s1 = w1_low;
      host_op(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (wr_cyc - s_w != 1 || w0_low - s0 != 1 || w1_low - s1 != 0) begin
         n_fail++;
         $display("FAIL single_write: got wr_cycles=%0d h0_low=%0d h1_low=%0d, required 1/1/0",
                  wr_cyc - s_w, w0_low - s0, w1_low - s1);
      end
   endtask

   task automatic test_dual_read();
      int base;
      do_reset();
      base = order_q.size();
      fork
         host_op(0, 1'b0, 32'h0000_0200, 32'h0);
         host_op(1, 1'b0, 32'h0000_0300, 32'h0);
      join
      drain();
      n_chk++;
      if (order_q.size() != base + 2 || order_q[base] != 0 || order_q[base+1] != 1) begin
         n_fail++;
         $display("FAIL dual_read_order: got %0d grants, first=%0d, required 2 grants h0 then h1",
                  order_q.size() - base, (order_q.size() > base) ? order_q[base] : -1);
      end
   endtask

   task automatic stream(input int h);
      for (int i = 0; i < 4; i++)
         host_op(h, 1'b1, 32'h0000_1000 + 32'(h * 256 + i * 4), 32'hA500_0000 + 32'(h * 16 + i));
   endtask

   task automatic test_back_to_back();
      int base = order_q.size();
      int s_w = wr_cyc;
      fork
         stream(0);
         stream(1);
      join
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (wr_cyc - s_w != 8 || order_q.size() - base != 8) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d write cycles %0d grants, required 8/8", wr_cyc - s_w, order_q.size() - base);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (order_q[base+i] != i % 2) begin
               n_fail++;
               $display("FAIL b2b_order[%0d]: got h%0d, required h%0d", i, order_q[base+i], i % 2);
            end
         end
      end
   endtask

   task automatic test_wait_stall();
      int base = order_q.size();
      int s_r = rd_cyc;
      stall_req = stall_used + 5;
      fork
         host_op(1, 1'b0, 32'h0000_0400, 32'h0);
         begin
            @(posedge clk);
            #1;
            host_op(0, 1'b1, 32'h0000_0500, 32'h1234_5678);
         end
      join
      drain();
      n_chk++;
      if (rd_cyc - s_r != 6) begin
         n_fail++;
         $display("FAIL stall_read_cycles: got %0d, required 6", rd_cyc - s_r);
      end
      n_chk++;
      if (order_q.size() != base + 2 || order_q[base] != 1 || order_q[base+1] != 0) begin
         n_fail++;
         $display("FAIL stall_order: got %0d grants, required h1 then h0", order_q.size() - base);
      end
   endtask

   task automatic test_spurious();
      repeat (2) @(posedge clk);
      #1;
      spur = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.h0_readdatavalid !== 1'b0 || bus.h1_readdatavalid !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_rdv: got v0=%b v1=%b, required 0/0", bus.h0_readdatavalid, bus.h1_readdatavalid);
      end
      n_chk++;
      if (bus.h0_readdata !== bus.sdram_readdata || bus.h1_readdata !== bus.sdram_readdata) begin
         n_fail++;
         $display("FAIL readdata_mirror: got %h/%h, required %h", bus.h0_readdata, bus.h1_readdata, bus.sdram_readdata);
      end
      @(posedge clk);
      #1;
      spur = 1'b0;
   endtask

   task automatic test_reset_midread();
      int s_w;
      host_op(1, 1'b0, 32'h0000_0600, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      rdq1.delete();
      n_chk++;
      if (bus.sdram_read !== 1'b0 || bus.sdram_write !== 1'b0 || bus.h0_waitrequest !== 1'b1 ||
          bus.h1_waitrequest !== 1'b1 || bus.sdram_address !== 32'h0) begin
         n_fail++;
         $display("FAIL midread_reset: got rd=%b wr=%b w0=%b w1=%b addr=%h, required 0 0 1 1 0",
                  bus.sdram_read, bus.sdram_write, bus.h0_waitrequest, bus.h1_waitrequest, bus.sdram_address);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.h0_readdatavalid !== 1'b0 || bus.h1_readdatavalid !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_rdv: got v0=%b v1=%b, required 0/0", bus.h0_readdatavalid, bus.h1_readdatavalid);
      end
      @(posedge clk);
      #1;
      s_w = wr_cyc;
      host_op(1, 1'b1, 32'h0000_0700, 32'hCAFE_F00D);
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (wr_cyc - s_w != 1) begin
         n_fail++;
         $display("FAIL post_reset_write: got %0d write cycles, required 1", wr_cyc - s_w);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_write();
      test_dual_read();
      test_back_to_back();
      test_wait_stall();
      test_spurious();
      test_reset_midread();
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
